// File: rtl/i2c_tgt_pkg.sv
// Shared types and constants for the I2C target receiver.
// The only item that needs explanation is the write unpacker.
package i2c_tgt_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_BYTE1,
    S_ACK1,
    S_BYTE2,
    S_ACK2,
    S_IGNORE
  } state_t;

  localparam int   BYTE_BITS = 8;
  localparam logic RW_WRITE  = 1'b0;

  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] data;
  } wr_pair_t;

  // The first data byte carries the 7-bit register address and the data MSB.
  function automatic wr_pair_t unpack_write(input logic [7:0] byte1,
                                            input logic [7:0] byte2);
    wr_pair_t p;
    p.addr = byte1[7:1];
    p.data = {byte1[0], byte2};
    return p;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser and bus-event detector (scl_rise, scl_fall, START, STOP).
// Define I2C_TGT_GLITCH_FILTER_EN to add a 3-sample majority filter per line.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_line;
  logic                   sda_line;
  logic                   scl_hist_q;
  logic                   sda_hist_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  // Reset to 1 (idle bus) so releasing reset on an idle bus creates no events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [2:0] scl_flt_q;
  logic [2:0] sda_flt_q;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_flt_q <= '1;
      sda_flt_q <= '1;
    end else begin
      scl_flt_q <= {scl_flt_q[1:0], scl_sync_q[SYNC_STAGES-1]};
      sda_flt_q <= {sda_flt_q[1:0], sda_sync_q[SYNC_STAGES-1]};
    end
  end

  // A single-cycle pulse occupies only one of three samples and is outvoted.
  assign scl_line = maj3(scl_flt_q);
  assign sda_line = maj3(sda_flt_q);
`else
  assign scl_line = scl_sync_q[SYNC_STAGES-1];
  assign sda_line = sda_sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_hist_q <= scl_line;
      sda_hist_q <= sda_line;
    end
  end

  assign sda_o      = sda_line;
  assign scl_rise_o = scl_line & ~scl_hist_q;
  assign scl_fall_o = ~scl_line & scl_hist_q;
  // START/STOP need SCL high both before and after the SDA transition.
  assign start_o    = scl_line & scl_hist_q & sda_hist_q & ~sda_line;
  assign stop_o     = scl_line & scl_hist_q & ~sda_hist_q & sda_line;

endmodule

// File: rtl/i2c_target_rx.sv
// I2C target receiving 3-byte register writes {dev_addr+W, {addr,d8}, d[7:0]}.
// Optional macro I2C_TGT_GLITCH_FILTER_EN enables the input majority filter.
module i2c_target_rx
  import i2c_tgt_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i2c_sclk,
  inout  wire        i2c_sdat,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  output logic       busy,
  output logic       err
);

  localparam logic [3:0] CNT_LAST = 4'(BYTE_BITS - 1);
  localparam logic [3:0] CNT_ACK  = 4'(BYTE_BITS);

  logic sda_in;
  logic scl_rise;
  logic scl_fall;
  logic start_ev;
  logic stop_ev;

  state_t     state_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic [7:0] byte1_q;
  logic       sda_low_q;
  logic       wr_valid_q;
  logic [6:0] wr_addr_q;
  logic [8:0] wr_data_q;
  logic       busy_q;
  logic       err_q;

  logic [7:0] shift_d;
  logic       byte_done;
  wr_pair_t   pair_d;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (i2c_sclk),
    .sda_i     (i2c_sdat),
    .sda_o     (sda_in),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_ev),
    .stop_o    (stop_ev)
  );

  assign shift_d   = {shift_q[6:0], sda_in};
  assign byte_done = (bit_cnt_q == CNT_LAST);
  assign pair_d    = unpack_write(byte1_q, shift_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte1_q    <= '0;
      sda_low_q  <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_valid_q <= 1'b0;
      err_q      <= 1'b0;
      if (stop_ev) begin
        // A STOP before the second data byte completes is an aborted write.
        if (busy_q && (state_q inside {S_ADDR_ACK, S_BYTE1, S_ACK1, S_BYTE2}))
          err_q <= 1'b1;
        state_q   <= S_IDLE;
        busy_q    <= 1'b0;
        sda_low_q <= 1'b0;
        bit_cnt_q <= '0;
      end else if (start_ev) begin
        state_q   <= S_ADDR;
        busy_q    <= 1'b0;
        sda_low_q <= 1'b0;
        bit_cnt_q <= '0;
      end else if (scl_rise) begin
        case (state_q)
          S_ADDR, S_BYTE1, S_BYTE2: begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (byte_done) begin
              case (state_q)
                S_ADDR: begin
                  if (shift_d[7:1] == DEV_ADDR && shift_d[0] == RW_WRITE) begin
                    state_q <= S_ADDR_ACK;
                    busy_q  <= 1'b1;
                  end else begin
                    // Counter lands on CNT_ACK, so IGNORE skips this byte's ACK slot.
                    state_q <= S_IGNORE;
                    if (shift_d[7:1] == DEV_ADDR) err_q <= 1'b1;
                  end
                end
                S_BYTE1: begin
                  byte1_q <= shift_d;
                  state_q <= S_ACK1;
                end
                S_BYTE2: begin
                  wr_valid_q <= 1'b1;
                  wr_addr_q  <= pair_d.addr;
                  wr_data_q  <= pair_d.data;
                  state_q    <= S_ACK2;
                end
                default: ;
              endcase
            end
          end
          S_IGNORE: begin
            if (bit_cnt_q == CNT_ACK) begin
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (byte_done) err_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        if (state_q inside {S_ADDR_ACK, S_ACK1, S_ACK2}) begin
          // First fall after bit 8 drives ACK; the next fall releases and moves on.
          if (!sda_low_q) begin
            sda_low_q <= 1'b1;
          end else begin
            sda_low_q <= 1'b0;
            bit_cnt_q <= '0;
            case (state_q)
              S_ADDR_ACK: state_q <= S_BYTE1;
              S_ACK1:     state_q <= S_BYTE2;
              default:    state_q <= S_IGNORE;
            endcase
          end
        end
      end
    end
  end

  assign i2c_sdat = sda_low_q ? 1'b0 : 1'bz;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: bit-banged I2C initiator, write scoreboard and
// err-pulse counter driven by a monitor process, ACK length measured on the bus.
module tb_i2c_target_rx;

  localparam int HALF  = 20;  // SCL half period in clk cycles
  localparam int SETUP = 8;   // clk cycles after SCL fall before SDA changes

  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda_low = 1'b0;
  wire        sda_bus;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic       busy;
  logic       err;

  int   vectors = 0;
  int   miscompares = 0;
  int   since_fall = 0;
  int   low_cnt = 0;
  bit   cnt_en = 1'b0;
  int   err_cnt = 0;
  int   e0;
  exp_t exp_q[$];

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_target_rx dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i2c_sclk(m_scl),
    .i2c_sdat(sda_bus),
    .wr_valid(wr_valid),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every write strobe and tallies err pulses.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (err) err_cnt++;
      if (wr_valid) begin
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 32'(wr_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e.addr));
          check("wr_data", 32'(wr_data), 32'(e.data));
        end
      end
    end
  end

  always @(posedge clk) if (cnt_en && sda_bus === 1'b0) low_cnt++;

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      since_fall++;
    end
  endtask

  task automatic wait_until(input int n);
    if (since_fall < n) tick(n - since_fall);
  endtask

  task automatic drop_scl();
    m_scl = 1'b0;
    since_fall = 0;
  endtask

  task automatic i2c_start();
    if (!m_scl) begin
      wait_until(SETUP);
      m_sda_low = 1'b0;
      wait_until(HALF);
      m_scl = 1'b1;
      tick(HALF / 2);
    end
    m_sda_low = 1'b1;
    tick(HALF / 2);
    drop_scl();
    tick(1);
  endtask

  task automatic i2c_stop();
    wait_until(SETUP);
    m_sda_low = 1'b1;
    wait_until(HALF);
    m_scl = 1'b1;
    tick(HALF / 2);
    m_sda_low = 1'b0;
    tick(2 * HALF);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      wait_until(SETUP);
      m_sda_low = !b[i];
      wait_until(HALF);
      m_scl = 1'b1;
      tick(HALF);
      drop_scl();
      tick(1);
    end
  endtask

  // ACK slot: the target must hold SDA low for exactly one SCL period.
  task automatic ack_slot(input string name, input bit exp_ack);
    logic got;
    m_sda_low = 1'b0;
    low_cnt   = 0;
    cnt_en    = 1'b1;
    wait_until(HALF);
    m_scl = 1'b1;
    tick(HALF / 2);
    got = !sda_bus;
    tick(HALF - HALF / 2);
    drop_scl();
    tick(SETUP);
    cnt_en = 1'b0;
    check({name, "_ack"}, 32'(got), 32'(exp_ack));
    check({name, "_ack_len"}, 32'(low_cnt), exp_ack ? 32'(2 * HALF) : 32'd0);
  endtask

  task automatic send_byte(input string name, input logic [7:0] b, input bit exp_ack);
    send_bits(b, 8);
    ack_slot(name, exp_ack);
  endtask

  initial begin
    tick(10);
    rst_n = 1'b1;
    tick(10);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_sda", 32'(sda_bus), 32'd1);

    // Basic write: reg 0x0F <= 0x000
    e0 = err_cnt;
    i2c_start();
    send_byte("t1_dev", 8'h34, 1'b1);
    check("t1_busy", 32'(busy), 32'd1);
    send_byte("t1_b1", 8'h1E, 1'b1);
    exp_q.push_back(exp_t'{addr: 7'h0F, data: 9'h000});
    send_byte("t1_b2", 8'h00, 1'b1);
    i2c_stop();
    check("t1_busy_stop", 32'(busy), 32'd0);
    check("t1_err", 32'(err_cnt - e0), 32'd0);
    check("t1_drained", 32'(exp_q.size()), 32'd0);

    // Write with data MSB set: reg 0x09 <= 0x1A5
    e0 = err_cnt;
    i2c_start();
    send_byte("t2_dev", 8'h34, 1'b1);
    send_byte("t2_b1", 8'h13, 1'b1);
    exp_q.push_back(exp_t'{addr: 7'h09, data: 9'h1A5});
    send_byte("t2_b2", 8'hA5, 1'b1);
    i2c_stop();
    check("t2_err", 32'(err_cnt - e0), 32'd0);

    // Other device (no err) then read to our address (err)
    e0 = err_cnt;
    i2c_start();
    send_byte("t3_mismatch", 8'h36, 1'b0);
    i2c_stop();
    check("t3_err_mismatch", 32'(err_cnt - e0), 32'd0);
    i2c_start();
    send_byte("t3_read", 8'h35, 1'b0);
    i2c_stop();
    check("t3_err_read", 32'(err_cnt - e0), 32'd1);

    // Aborted write, then repeated START mid-byte and a full write
    e0 = err_cnt;
    i2c_start();
    send_byte("t4_dev", 8'h34, 1'b1);
    send_byte("t4_b1", 8'h1E, 1'b1);
    i2c_stop();
    check("t4_abort_err", 32'(err_cnt - e0), 32'd1);
    check("t4_hold_addr", 32'(wr_addr), 32'h09);
    check("t4_hold_data", 32'(wr_data), 32'h1A5);
    check("t4_busy", 32'(busy), 32'd0);
    e0 = err_cnt;
    i2c_start();
    send_bits(8'h34, 4);
    i2c_start();
    send_byte("t4_dev2", 8'h34, 1'b1);
    send_byte("t4_b1b", 8'h12, 1'b1);
    exp_q.push_back(exp_t'{addr: 7'h09, data: 9'h001});
    send_byte("t4_b2b", 8'h01, 1'b1);
    i2c_stop();
    check("t4_err_rs", 32'(err_cnt - e0), 32'd0);

    // Four-byte write: extra byte NACKed with one err pulse
    e0 = err_cnt;
    i2c_start();
    send_byte("t5_dev", 8'h34, 1'b1);
    send_byte("t5_b1", 8'h1E, 1'b1);
    exp_q.push_back(exp_t'{addr: 7'h0F, data: 9'h000});
    send_byte("t5_b2", 8'h00, 1'b1);
    send_byte("t5_b3", 8'hFF, 1'b0);
    i2c_stop();
    check("t5_err", 32'(err_cnt - e0), 32'd1);
    check("t5_drained", 32'(exp_q.size()), 32'd0);

    // Reset asserted while the target drives the address ACK
    i2c_start();
    send_bits(8'h34, 8);
    m_sda_low = 1'b0;
    wait_until(HALF / 2);
    check("t6_acking", 32'(sda_bus), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_sda_released", 32'(sda_bus), 32'd1);
    check("t6_wr_valid", 32'(wr_valid), 32'd0);
    check("t6_wr_addr", 32'(wr_addr), 32'd0);
    check("t6_wr_data", 32'(wr_data), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_err", 32'(err), 32'd0);
    tick(2);
    m_scl = 1'b1;
    tick(HALF);
    rst_n = 1'b1;
    tick(HALF);
    check("t6_idle_busy", 32'(busy), 32'd0);
    check("t6_idle_sda", 32'(sda_bus), 32'd1);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_target_rx.md
Name: i2c_target_rx

Overview:
I2C target (slave) receiver for the 3-byte codec control write: device address byte, then two data bytes packed as {reg_addr[6:0], reg_data[8]} and reg_data[7:0].
- Sits on the same two-wire bus the codec-config controller drives.
- Two uses: a loopback/self-check target in FPGA test builds, and an on-chip register-write endpoint.
- Decodes START/STOP, ACKs matching writes, and emits one write strobe per complete transfer.

Parameters:
DEV_ADDR, 7'h1A, 7-bit target address that this block ACKs.
SYNC_STAGES, 2, flops in the SCL/SDA input synchroniser (minimum 2).

Ports:
clk  input  1  system clock; must be at least 16x the SCL frequency.
rst_n  input  1  asynchronous active-low reset.
i2c_sclk  input  1  bus clock from the initiator.
i2c_sdat  inout  1  bus data, open-drain; the block only ever drives 0 or Z.
wr_valid  output  1  one-cycle strobe: wr_addr/wr_data hold a complete, acknowledged write.
wr_addr  output  7  register address of the last complete write.
wr_data  output  9  register data of the last complete write.
busy  output  1  high from an addressed START until the following STOP/abort.
err  output  1  one-cycle strobe on a protocol error (see Behaviour).

Behaviour:
- Reset (async, rst_n=0): SDA released (Z), state IDLE, wr_valid=0, wr_addr=0, wr_data=0, busy=0, err=0. Reset asserted mid-ACK releases SDA immediately.
- Input conditioning:
  - SCL/SDA pass through SYNC_STAGES flops plus one history flop.
  - All bus events are detected SYNC_STAGES+1 clk after the pin changes.
  - Events: scl_rise, scl_fall, START (SDA fall while SCL high), STOP (SDA rise while SCL high).
- Bit timing:
  - Data bits sampled on scl_rise, MSB first, into an 8-bit shift register.
  - ACK: SDA driven low on the scl_fall after the 8th bit, released on the next scl_fall.
- States: IDLE, ADDR, ADDR_ACK, BYTE1, ACK1, BYTE2, ACK2, IGNORE.
  - IDLE: START -> ADDR, bit counter cleared.
  - ADDR: after 8 bits, compare byte[7:1] with DEV_ADDR and require R/W (byte[0]) = 0.
    - Match and write -> ADDR_ACK, busy=1.
    - Address mismatch -> IGNORE, no ACK, no err.
    - Match with R/W=1 -> IGNORE, no ACK, err pulse.
  - ADDR_ACK -> BYTE1 at the ACK-release scl_fall.
  - BYTE1: after 8 bits -> ACK1, byte held.
  - ACK1 -> BYTE2.
  - BYTE2: after 8 bits -> ACK2.
    - wr_addr=byte1[7:1], wr_data={byte1[0], byte2}.
    - wr_valid pulses on the clk after the 8th scl_rise, before the ACK is driven.
  - ACK2 -> IGNORE at ACK release.
  - IGNORE: SDA stays released; any further complete byte is NACKed and pulses err once per byte.
- Priority and boundaries:
  - STOP in any state -> IDLE, busy=0.
  - START (repeated) in any state -> ADDR, counter cleared; takes priority over a same-cycle scl event.
  - STOP before BYTE2 completes aborts: no wr_valid, err pulse if busy was 1.
  - wr_addr/wr_data change only on wr_valid and hold otherwise.
- Bit counter is 4 bits and is cleared on START and on each ACK-phase exit; it never wraps within a byte.

Optional Feature:
I2C_TGT_GLITCH_FILTER_EN:
- Defined: each synchronised line passes a 3-sample majority filter before edge detection. Pulses shorter than 2 clk are rejected; event latency becomes SYNC_STAGES+3 clk.
- Undefined: no filter; latency SYNC_STAGES+1 clk.

Decomposition:
- Package i2c_tgt_pkg holds:
  - the state_t enum (3-bit);
  - constants BYTE_BITS=8 and RW_WRITE=1'b0;
  - a helper function unpacking {byte1, byte2} into addr/data.
- One sub-module, i2c_bus_sync: synchroniser, optional majority filter, and scl_rise/scl_fall/START/STOP detection.

Test Plan:
- Write 0x34,0x1E,0x00 -> ACK on all 3 bytes; wr_valid once with wr_addr=0x0F, wr_data=0x000; busy falls at STOP.
- Write 0x34,0x13,0xA5 -> wr_addr=0x09, wr_data=0x1A5; SDA low for exactly one SCL period at each ACK.
- Address 0x36 (mismatch) then 0x35 (read to 0x1A) -> no ACK for either, no wr_valid; err only for 0x35.
- 0x34,0x1E then STOP -> no wr_valid, err=1 once; outputs keep previous values. Then repeated START mid-byte, followed by a full write 0x34,0x12,0x01 -> wr_addr=0x09, wr_data=0x001.
- 4-byte write 0x34,0x1E,0x00,0xFF -> wr_valid once; 4th byte NACKed with err pulse.
- rst_n low while SDA is driven for ADDR_ACK -> SDA Z within the same cycle, all outputs at reset values.
